// File: rtl/sub_pkg.sv
// Shared definitions for the bit-serial subtractor: controller states and default width.
package sub_pkg;

    localparam int SUB_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: dif = a - b - c, bo = borrow-out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic dif,
    output logic bo
);

    assign dif = a ^ b ^ c;
    assign bo  = (~a & b) | (~a & c) | (b & c);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial subtractor controller: one full-subtractor cell, LSB first, one bit per clock.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module serial_sub_ctrl
    import sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dif,
    output logic             bo
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    state_t           nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [WIDTH-1:0] res_nxt;
    logic [CW-1:0]    cnt;
    logic             brw;
    logic             cell_dif;
    logic             cell_bo;
    logic             last;

    full_subtractor u_fs (
        .a   (a_sr[0]),
        .b   (b_sr[0]),
        .c   (brw),
        .dif (cell_dif),
        .bo  (cell_bo)
    );

    assign last    = (cnt == CW'(WIDTH - 1));
    // Result bits enter from the MSB side; bit 0 only exists in the final word.
    assign res_nxt = {cell_dif, res_sr};

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt  = state;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            IDLE: begin
                if (start) nxt = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (last) nxt = DONE;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
                nxt  = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            brw    <= 1'b0;
            dif    <= '0;
            bo     <= 1'b0;
`ifdef SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr <= a;
                        b_sr <= b;
                        brw  <= bin;
                        cnt  <= '0;
                    end
                end
                SHIFT: begin
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    res_sr <= res_nxt[WIDTH-1:1];
                    brw    <= cell_bo;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        dif <= res_nxt;
                        bo  <= cell_bo;
`ifdef SUB_OVF_EN
                        // brw still holds the borrow into the MSB on this cycle.
                        ovf <= brw ^ cell_bo;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl (WIDTH=8); checks ovf when SUB_OVF_EN is defined.
module tb_serial_sub_ctrl;

    localparam int W = 8;

    typedef struct packed {
        logic [W-1:0] dif;
        logic         bo;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] dif;
    logic         bo;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    int   ntests = 0;
    int   nfail  = 0;
    int   cyc    = 0;
    int   done_cnt = 0;
    exp_t exp_q[$];
    int   done_cyc[$];

    serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .dif   (dif),
        .bo    (bo)
`ifdef SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        ntests++;
        if (act != req) begin
            nfail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expected result.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            done_cnt++;
            done_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("dif", int'(dif), int'(e.dif));
                check("bo", int'(bo), int'(e.bo));
`ifdef SUB_OVF_EN
                check("ovf", int'(ovf), int'(e.ovf));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op; optionally inject a competing start at edge 'inj' after launch.
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tbin,
                          input logic [W-1:0] edif, input logic ebo, input logic eovf,
                          input int inj);
        int n;
        exp_q.push_back('{dif: edif, bo: ebo, ovf: eovf});
        a = ta; b = tbv; bin = tbin; start = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
            start = 1'b0;
            a = W'($urandom);
            b = W'($urandom);
            bin = 1'($urandom);
            if (n == inj) begin
                a = 8'h10; b = 8'h01; bin = 1'b0; start = 1'b1;
            end
        end while (!done && n < 30);
        start = 1'b0;
        check("latency", n, W + 1);
        tick();
    endtask

    initial begin
        int base;
        int k;
        int n;
        bit held_checked;

        tick(); tick();
        rst = 1'b0;
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_dif", int'(dif), 0);
        check("rst_bo", int'(bo), 0);

        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0);
        run_op(8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0, 0);
        run_op(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
        run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);

        repeat (4) tick();
        check("hold_dif", int'(dif), 8'h7F);
        check("hold_busy", int'(busy), 0);

        // Competing start three cycles into an op must be dropped.
        base = done_cnt;
        run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 3);
        repeat (15) tick();
        check("ignored_start_single_done", done_cnt - base, 1);
        check("ignored_start_dif", int'(dif), 8'h02);

        // Reset in the middle of an op aborts it without a done pulse.
        base = done_cnt;
        a = 8'h05; b = 8'h03; bin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_dif", int'(dif), 0);
        check("abort_bo", int'(bo), 0);
        rst = 1'b0;
        repeat (12) tick();
        check("abort_no_done", done_cnt - base, 0);
        run_op(8'h0F, 8'h0A, 1'b0, 8'h05, 1'b0, 1'b0, 0);

        // Start held high: back-to-back ops every 10 cycles.
        for (int i = 0; i < 3; i++) exp_q.push_back('{dif: 8'hEB, bo: 1'b1, ovf: 1'b0});
        a = 8'h30; b = 8'h45; bin = 1'b0; start = 1'b1;
        k = 0; n = 0; held_checked = 1'b0;
        while (k < 3 && n < 60) begin
            tick();
            n++;
            if (done) begin
                k++;
                if (k == 3) start = 1'b0;
            end else if (k >= 1 && busy && !held_checked) begin
                check("b2b_held_dif", int'(dif), 8'hEB);
                held_checked = 1'b1;
            end
        end
        start = 1'b0;
        check("b2b_done_count", k, 3);
        repeat (15) tick();
        check("b2b_idle", int'(busy), 0);
        if (done_cyc.size() >= 3) begin
            check("b2b_period_1", done_cyc[done_cyc.size()-2] - done_cyc[done_cyc.size()-3], 10);
            check("b2b_period_2", done_cyc[done_cyc.size()-1] - done_cyc[done_cyc.size()-2], 10);
        end else begin
            check("b2b_done_history", done_cyc.size(), 3);
        end

        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
